multiport_cache: RTL and testbench

Parametrised successor to the two-port CPU-side cache: direct-mapped, write-through, no-write-allocate cache serving `PORTS` CPU request ports from a single memory port. Sits between the CPU load/store units and the data-memory interface in the peripheral system wrapper. Adds round-robin port arbitration, a valid/ready memory handshake, uncached bypass and a sequenced flush.

---
 rtl/multiport_cache_pkg.sv | 20 ++
 rtl/multiport_cache_rr_arbiter.sv | 45 ++++
 rtl/multiport_cache.sv | 164 ++++++++++++++++
 tb/tb_multiport_cache.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/multiport_cache_pkg.sv
// Shared definitions for the multi-port write-through cache: controller state
// encodings and the index-width helper.
package cache_pkg;

   typedef logic [2:0] cacheState_t;

   localparam cacheState_t ST_IDLE      = 3'd0;
   localparam cacheState_t ST_LOOKUP    = 3'd1;
   localparam cacheState_t ST_FILL_REQ  = 3'd2;
   localparam cacheState_t ST_FILL_WAIT = 3'd3;
   localparam cacheState_t ST_WR_REQ    = 3'd4;
   localparam cacheState_t ST_RESP      = 3'd5;
   localparam cacheState_t ST_FLUSH     = 3'd6;

   // Width needed to index `count` entries; never narrower than one bit.
   function automatic int idxWidth(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/multiport_cache_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last granted port
// and remembers that port for the next round.
module rr_arbiter
   import cache_pkg::*;
#(
   parameter int PORTS = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PORTS-1:0] req,
   input  logic             enable,
   output logic [PORTS-1:0] grant
);

   localparam int PTR_W = idxWidth(PORTS);

   logic [PTR_W-1:0] lastPtr;
   logic [PTR_W-1:0] nextPtr;

   // NOTE: every output gets a default before the search so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      grant   = '0;
      nextPtr = lastPtr;
      // Walk offsets from farthest to nearest so the nearest requester wins.
      for (int off = PORTS; off >= 1; off--) begin
         for (int j = 0; j < PORTS; j++) begin
            if (enable && req[j] && (j == (int'(lastPtr) + off) % PORTS)) begin
               grant    = '0;
               grant[j] = 1'b1;
               nextPtr  = PTR_W'(j);
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         lastPtr <= PTR_W'(PORTS - 1);
      end else if (|grant) begin
         lastPtr <= nextPtr;
      end
   end

endmodule

// File: rtl/multiport_cache.sv
// Direct-mapped, write-through, no-write-allocate cache shared by PORTS CPU
// ports over one valid/ready memory port, with uncached bypass and flush.
module multiport_cache
   import cache_pkg::*;
#(
   parameter int PORTS  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 40,
   parameter int LINES  = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cache_en,
   input  logic                    flush,
   output logic                    flush_busy,
   input  logic [PORTS-1:0]        cpu_req,
   input  logic [PORTS-1:0]        cpu_we,
   input  logic [PORTS*ADDR_W-1:0] cpu_addr,
   input  logic [PORTS*DATA_W-1:0] cpu_wdata,
   output logic [PORTS-1:0]        cpu_ack,
   output logic [DATA_W-1:0]       cpu_rdata,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   input  logic                    mem_ready,
   input  logic                    mem_rvalid,
   input  logic [DATA_W-1:0]       mem_rdata
);

   localparam int IDX_W = idxWidth(LINES);
   localparam int TAG_W = ADDR_W - IDX_W;
   localparam int PTR_W = idxWidth(PORTS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

   cacheState_t state, nextState;

   logic [PORTS-1:0]  grant;
   logic [PTR_W-1:0]  grantIdx;
   logic              selWe;
   logic [ADDR_W-1:0] selAddr;
   logic [DATA_W-1:0] selWdata;

   logic [PTR_W-1:0]  reqPort;
   logic              reqWe;
   logic [ADDR_W-1:0] reqAddr;
   logic [DATA_W-1:0] reqWdata;
   logic [DATA_W-1:0] respData;
   logic [IDX_W-1:0]  flushCnt;

   logic [LINES-1:0]  validBits;
   logic [TAG_W-1:0]  tagArr  [LINES];
   logic [DATA_W-1:0] dataArr [LINES];

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  reqTag;
   logic              hit;
   logic              arrWe;
   logic [DATA_W-1:0] arrWdata;

   rr_arbiter #(.PORTS(PORTS)) uArb (
      .clk    (clk),
      .rst    (rst),
      .req    (cpu_req),
      .enable (state == ST_IDLE && !flush),
      .grant  (grant)
   );

   always_comb begin
      grantIdx = '0;
      selWe    = 1'b0;
      selAddr  = '0;
      selWdata = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (grant[i]) begin
            grantIdx = PTR_W'(i);
            selWe    = cpu_we[i];
            selAddr  = cpu_addr[i*ADDR_W +: ADDR_W];
            selWdata = cpu_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign idx    = reqAddr[IDX_W-1:0];
   assign reqTag = reqAddr[ADDR_W-1:IDX_W];
   assign hit    = cache_en && validBits[idx] && (tagArr[idx] == reqTag);

   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE:      if (flush) nextState = ST_FLUSH;
                       else if (|grant) nextState = ST_LOOKUP;
         ST_LOOKUP:    if (reqWe) nextState = ST_WR_REQ;
                       else if (hit) nextState = ST_RESP;
                       else nextState = ST_FILL_REQ;
         ST_FILL_REQ:  if (mem_ready) nextState = ST_FILL_WAIT;
         ST_FILL_WAIT: if (mem_rvalid) nextState = ST_RESP;
         ST_WR_REQ:    if (mem_ready) nextState = ST_RESP;
         ST_RESP:      nextState = ST_IDLE;
         ST_FLUSH:     if (flushCnt == LAST_IDX) nextState = ST_IDLE;
         default:      nextState = ST_IDLE;
      endcase
   end

   always_comb begin
      cpu_ack = '0;
      if (state == ST_RESP) cpu_ack[reqPort] = 1'b1;
      cpu_rdata  = respData;
      mem_req    = (state == ST_FILL_REQ) || (state == ST_WR_REQ);
      mem_we     = (state == ST_WR_REQ);
      mem_addr   = reqAddr;
      mem_wdata  = reqWdata;
      flush_busy = (state == ST_FLUSH);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         reqPort   <= '0;
         reqWe     <= 1'b0;
         reqAddr   <= '0;
         reqWdata  <= '0;
         respData  <= '0;
         flushCnt  <= '0;
         validBits <= '0;
      end else begin
         if (|grant) begin
            reqPort  <= grantIdx;
            reqWe    <= selWe;
            reqAddr  <= selAddr;
            reqWdata <= selWdata;
         end
         if (state == ST_FLUSH) begin
            validBits[flushCnt] <= 1'b0;
            flushCnt            <= flushCnt + IDX_W'(1);
         end else begin
            flushCnt <= '0;
         end
         if (state == ST_LOOKUP && !reqWe && hit) respData <= dataArr[idx];
         if (state == ST_FILL_WAIT && mem_rvalid) begin
            respData <= mem_rdata;
            if (cache_en) validBits[idx] <= 1'b1;
         end
      end
   end

   // Write hits and allocating fills are mutually exclusive by state.
   assign arrWe    = rst && (((state == ST_LOOKUP) && reqWe && hit) ||
                             ((state == ST_FILL_WAIT) && mem_rvalid && cache_en));
   assign arrWdata = (state == ST_FILL_WAIT) ? mem_rdata : reqWdata;

   // NOTE: tag/data arrays are not reset so they map onto RAM; validBits alone says which lines are live.
   always_ff @(posedge clk) begin
      if (arrWe) begin
         tagArr[idx]  <= reqTag;
         dataArr[idx] <= arrWdata;
      end
   end

endmodule

// File: tb/tb_multiport_cache.sv
// Directed bench for multiport_cache: a small memory responder plus one task
// per scenario, each comparing against hand-computed cycle counts and data.
module tb_multiport_cache;

   localparam int PORTS  = 2;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 40;
   localparam int LINES  = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic cache_en = 1'b1;
   logic flush = 1'b0;
   logic [PORTS-1:0] cpu_req = '0;
   logic [PORTS-1:0] cpu_we = '0;
   logic [PORTS*ADDR_W-1:0] cpu_addr = '0;
   logic [PORTS*DATA_W-1:0] cpu_wdata = '0;
   logic flush_busy;
   logic [PORTS-1:0] cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic mem_ready, mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   logic memReadyEn = 1'b1;
   logic autoRvalid = 1'b0;
   logic forceRvalid = 1'b0;
   logic [DATA_W-1:0] memData = '0;
   int memLatency = 2;
   int rvCountdown = 0;
   logic [ADDR_W-1:0] lastWrAddr = '0;
   logic [DATA_W-1:0] lastWrData = '0;
   int wrCount = 0;

   int checks = 0;
   int errors = 0;

   assign mem_ready  = memReadyEn;
   assign mem_rvalid = autoRvalid | forceRvalid;
   assign mem_rdata  = memData;

   always #5 clk = ~clk;

   multiport_cache #(.PORTS(PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES)) dut (
      .clk(clk), .rst(rst), .cache_en(cache_en), .flush(flush), .flush_busy(flush_busy),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   // Memory model: accepts on mem_req && mem_ready, returns read data memLatency cycles later.
   always @(negedge clk) begin
      autoRvalid = 1'b0;
      if (!rst) begin
         rvCountdown = 0;
      end else begin
         if (rvCountdown > 0) begin
            rvCountdown--;
            if (rvCountdown == 0) autoRvalid = 1'b1;
         end
         if (mem_req && mem_ready) begin
            if (mem_we) begin
               wrCount++;
               lastWrAddr = mem_addr;
               lastWrData = mem_wdata;
            end else begin
               rvCountdown = memLatency;
            end
         end
      end
   end

   // Drives one request; lat/memReqAt count falling edges after the request was raised (-1 = never).
   task automatic doReq(input int port, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, output int lat, output int memReqAt,
                        output logic [PORTS-1:0] ackVec, output logic [DATA_W-1:0] rdata);
      @(negedge clk);
      cpu_req[port] = 1'b1;
      cpu_we[port]  = we;
      cpu_addr[port*ADDR_W +: ADDR_W]  = addr;
      cpu_wdata[port*DATA_W +: DATA_W] = wdata;
      lat = -1; memReqAt = -1; ackVec = '0; rdata = '0;
      for (int n = 1; n <= 200 && lat < 0; n++) begin
         @(negedge clk);
         if (mem_req && memReqAt < 0) memReqAt = n;
         if (|cpu_ack) begin
            lat = n; ackVec = cpu_ack; rdata = cpu_rdata;
         end
      end
      cpu_req[port] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (cpu_ack !== '0) begin errors++; $display("FAIL reset_ack got %b want 0", cpu_ack); end
      checks++; if (cpu_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", cpu_rdata); end
      checks++; if ({mem_req, mem_we, flush_busy} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b want 000", {mem_req, mem_we, flush_busy}); end
      checks++; if ({mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
      rst = 1'b1;
   endtask

   task automatic test_read_miss_hit();
      int lat, mra; logic [PORTS-1:0] ack; logic [DATA_W-1:0] rd;
      memData = 40'hAB;
      doReq(0, 1'b0, 32'h10, '0, lat, mra, ack, rd);
      checks++; if (mra !== 2) begin errors++; $display("FAIL miss_memreq_cycle got %0d want 2", mra); end
      checks++; if (lat !== 5) begin errors++; $display("FAIL miss_ack_cycle got %0d want 5", lat); end
      checks++; if (ack !== 2'b01) begin errors++; $display("FAIL miss_ack_vec got %b want 01", ack); end
      checks++; if (rd !== 40'hAB) begin errors++; $display("FAIL miss_rdata got %h want ab", rd); end
      memData = 40'hFF;
      doReq(0, 1'b0, 32'h10, '0, lat, mra, ack, rd);
      checks++; if (lat !== 2) begin errors++; $display("FAIL hit_ack_cycle got %0d want 2", lat); end
      checks++; if (mra !== -1) begin errors++; $display("FAIL hit_no_memreq got %0d want -1", mra); end
      checks++; if (rd !== 40'hAB) begin errors++; $display("FAIL hit_rdata got %h want ab", rd); end
   endtask

   task automatic test_write();
      int lat, mra; logic [PORTS-1:0] ack; logic [DATA_W-1:0] rd;
      doReq(0, 1'b1, 32'h10, 40'h55, lat, mra, ack, rd);
      checks++; if (mra !== 2 || lat !== 3) begin errors++; $display("FAIL write_timing got memreq %0d ack %0d want 2 3", mra, lat); end
      checks++; if (lastWrAddr !== 32'h10 || lastWrData !== 40'h55) begin errors++; $display("FAIL write_mem got %h/%h want 10/55", lastWrAddr, lastWrData); end
      doReq(0, 1'b0, 32'h10, '0, lat, mra, ack, rd);
      checks++; if (lat !== 2 || rd !== 40'h55) begin errors++; $display("FAIL write_hit_update got ack %0d data %h want 2 55", lat, rd); end
      doReq(0, 1'b1, 32'h20, 40'h77, lat, mra, ack, rd);
      checks++; if (lat !== 3 || lastWrAddr !== 32'h20) begin errors++; $display("FAIL write_miss got ack %0d addr %h want 3 20", lat, lastWrAddr); end
      memData = 40'hCD;
      doReq(0, 1'b0, 32'h20, '0, lat, mra, ack, rd);
      checks++; if (mra !== 2 || lat !== 5 || rd !== 40'hCD) begin errors++; $display("FAIL no_write_allocate got memreq %0d ack %0d data %h want 2 5 cd", mra, lat, rd); end
   endtask

   task automatic test_bypass();
      int lat, mra; logic [PORTS-1:0] ack; logic [DATA_W-1:0] rd;
      cache_en = 1'b0;
      memData = 40'h99;
      doReq(0, 1'b0, 32'h10, '0, lat, mra, ack, rd);
      checks++; if (mra !== 2 || lat !== 5 || rd !== 40'h99) begin errors++; $display("FAIL bypass_read got memreq %0d ack %0d data %h want 2 5 99", mra, lat, rd); end
      cache_en = 1'b1;
      doReq(0, 1'b0, 32'h10, '0, lat, mra, ack, rd);
      checks++; if (lat !== 2 || rd !== 40'h55) begin errors++; $display("FAIL bypass_no_allocate got ack %0d data %h want 2 55", lat, rd); end
   endtask

   task automatic test_flush();
      int busyCnt, firstBusy, ackAt, ackInBusy, mra;
      logic [PORTS-1:0] ack; logic [DATA_W-1:0] rd;
      busyCnt = 0; firstBusy = -1; ackAt = -1; ackInBusy = 0; mra = -1; ack = '0; rd = '0;
      memData = 40'h3C;
      @(negedge clk);
      flush = 1'b1;
      cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[ADDR_W +: ADDR_W] = 32'h10;
      for (int n = 1; n <= 300 && ackAt < 0; n++) begin
         @(negedge clk);
         flush = 1'b0;
         if (flush_busy) begin
            busyCnt++;
            if (firstBusy < 0) firstBusy = n;
            if (|cpu_ack) ackInBusy++;
         end
         if (mem_req && mra < 0) mra = n;
         if (|cpu_ack) begin ackAt = n; ack = cpu_ack; rd = cpu_rdata; end
      end
      cpu_req[1] = 1'b0;
      checks++; if (busyCnt !== LINES || firstBusy !== 1) begin errors++; $display("FAIL flush_busy got %0d cycles from %0d want 64 from 1", busyCnt, firstBusy); end
      checks++; if (ackInBusy !== 0) begin errors++; $display("FAIL flush_req_waits got %0d acks want 0", ackInBusy); end
      checks++; if (ackAt !== 70 || mra !== 67) begin errors++; $display("FAIL flush_then_miss got ack %0d memreq %0d want 70 67", ackAt, mra); end
      checks++; if (ack !== 2'b10 || rd !== 40'h3C) begin errors++; $display("FAIL flush_resp got %b/%h want 10/3c", ack, rd); end
   endtask

   task automatic test_round_robin();
      logic [PORTS-1:0] expAck [3];
      logic [DATA_W-1:0] expData [3];
      logic [PORTS-1:0] ack; logic [DATA_W-1:0] rd;
      expAck  = '{2'b01, 2'b10, 2'b01};
      expData = '{40'h100, 40'h101, 40'h100};
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         memData  = 40'h100 + DATA_W'(r);
         cpu_we   = '0;
         cpu_addr = {32'h41, 32'h40};
         cpu_req  = 2'b11;
         ack = '0; rd = '0;
         for (int n = 0; n < 100 && ack == '0; n++) begin
            @(negedge clk);
            if (|cpu_ack) begin ack = cpu_ack; rd = cpu_rdata; end
         end
         cpu_req = '0;
         checks++; if (ack !== expAck[r]) begin errors++; $display("FAIL rr_grant%0d got %b want %b", r, ack, expAck[r]); end
         checks++; if (rd !== expData[r]) begin errors++; $display("FAIL rr_data%0d got %h want %h", r, rd, expData[r]); end
      end
   endtask

   task automatic test_reset_mid_stall();
      int lat, mra, stray; logic [PORTS-1:0] ack; logic [DATA_W-1:0] rd;
      memReadyEn = 1'b0;
      @(negedge clk);
      cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0 +: ADDR_W] = 32'h30;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         if (n >= 2) begin
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h30) begin errors++; $display("FAIL stall_stable%0d got %b%b %h want 10 30", n, mem_req, mem_we, mem_addr); end
         end
      end
      rst = 1'b0;
      cpu_req = '0;
      @(negedge clk);
      checks++; if (mem_req !== 1'b0 || cpu_ack !== '0) begin errors++; $display("FAIL stall_reset got req %b ack %b want 0 00", mem_req, cpu_ack); end
      rst = 1'b1;
      memReadyEn = 1'b1;
      memData = 40'hEE;
      forceRvalid = 1'b1;
      stray = 0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         forceRvalid = 1'b0;
         if (|cpu_ack || mem_req) stray++;
      end
      checks++; if (stray !== 0) begin errors++; $display("FAIL stray_rvalid got %0d active cycles want 0", stray); end
      memData = 40'h42;
      doReq(0, 1'b0, 32'h30, '0, lat, mra, ack, rd);
      checks++; if (lat !== 5 || rd !== 40'h42) begin errors++; $display("FAIL after_reset_read got ack %0d data %h want 5 42", lat, rd); end
   endtask

   initial begin
      test_reset();
      test_read_miss_hit();
      test_write();
      test_bypass();
      test_flush();
      test_round_robin();
      test_reset_mid_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
